vend_controller: RTL

Sequencing controller for a multi-product vending channel.
- Accumulates coin credit and holds a software-configurable price table.
- Arbitrates cancel, selection and coin events.
- Drives a req/ack handshake to the dispense mechanism, then returns change as unit pulses.
- Sits between the coin validator/keypad front end and the dispenser/change hopper.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_price_table.sv | 34 +++
 rtl/vend_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin decode for the vending controller
// Contents:
//   vend_state_e  controller states IDLE/CREDIT/DISPENSE/CHANGE
//   COIN_*        2-bit coin codes from the validator
//   coin_decode   coin code -> value in credit units (COIN_W bits, zero-extend at use)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  // Wide enough for the largest coin; callers widen to the credit width.
  localparam int COIN_W = 4;

  function automatic logic [COIN_W-1:0] coin_decode(input logic [1:0] code);
    logic [COIN_W-1:0] units;
    case (code)
      COIN_1:  units = 4'd1;
      COIN_2:  units = 4'd2;
      COIN_5:  units = 4'd5;
      default: units = 4'd10;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_price_table.sv
// rtl/vend_price_table.sv - NPROD x CREDIT_W price register file
// Ports:
//   clk, rst            clock, async active-high reset (all prices -> 0)
//   we, wr_idx, wr_price  write port, takes effect at the next rising edge
//   rd_idx, rd_price    combinational read port (returns pre-write value in a write cycle)
module vend_price_table
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6,
  parameter int NPROD    = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [CREDIT_W-1:0] wr_price,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CREDIT_W-1:0] rd_price
);

  logic [CREDIT_W-1:0] prices [NPROD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPROD; i++) prices[i] <= '0;
    end else if (we) begin
      prices[wr_idx] <= wr_price;
    end
  end

  assign rd_price = prices[rd_idx];

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending channel sequencer: credit, selection, dispense handshake, change
// Ports:
//   clk, rst                     clock, async active-high reset
//   coin_valid, coin_val         coin strobe and 2-bit coin code
//   coin_reject                  registered pulse: coin returned, credit unchanged
//   sel_valid, sel_idx, sel_nak  product select strobe/index, registered refusal pulse
//   cancel                       refund request strobe
//   cfg_we, cfg_idx, cfg_price   price table write port
//   disp_req, disp_idx, disp_ack dispense handshake to the mechanism
//   chg_pulse                    registered pulse per unit of change returned
//   credit, busy                 current credit; high in DISPENSE and CHANGE
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 6,
  parameter int NPROD      = 4,
  parameter int MAX_CREDIT = 50,
  parameter int TIMEOUT    = 200,
  localparam int IDX_W     = $clog2(NPROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  output logic                sel_nak,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CREDIT_W-1:0] cfg_price,
  output logic                disp_req,
  output logic [IDX_W-1:0]    disp_idx,
  input  logic                disp_ack,
  output logic                chg_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int                TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W:0] MAX_SUM  = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [IDX_W-1:0]    disp_idx_q, disp_idx_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_nak_q, sel_nak_d;
  logic                chg_pulse_q, chg_pulse_d;
  logic                gap_q, gap_d;

  logic [CREDIT_W-1:0] price_rd;
  logic [CREDIT_W-1:0] coin_units;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                price_ok;

  vend_price_table #(
    .CREDIT_W (CREDIT_W),
    .NPROD    (NPROD),
    .IDX_W    (IDX_W)
  ) u_price_table (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we),
    .wr_idx   (cfg_idx),
    .wr_price (cfg_price),
    .rd_idx   (sel_idx),
    .rd_price (price_rd)
  );

  assign coin_units = CREDIT_W'(coin_decode(coin_val));
  // One guard bit so the ceiling check cannot be fooled by wrap-around.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_units};
  assign coin_fits  = (coin_sum <= MAX_SUM);
  // A zero price marks an unconfigured product, never a free one.
  assign price_ok   = (price_rd != '0) && (credit_q >= price_rd);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    tmo_d         = '0;
    disp_idx_d    = disp_idx_q;
    coin_reject_d = 1'b0;
    sel_nak_d     = 1'b0;
    chg_pulse_d   = 1'b0;
    gap_d         = 1'b0;

    case (state_q)
      IDLE: begin
        sel_nak_d = sel_valid;
        if (coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      CREDIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (cancel) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid && price_ok) begin
          credit_d      = credit_q - price_rd;
          disp_idx_d    = sel_idx;
          state_d       = DISPENSE;
          coin_reject_d = coin_valid;
        end else begin
          if (sel_valid) begin
            sel_nak_d = 1'b1;
            tmo_d     = '0;
          end
          if (coin_valid) begin
            if (coin_fits) begin
              credit_d = coin_sum[CREDIT_W-1:0];
              tmo_d    = '0;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
          // Only a fully idle cycle at the last count triggers the refund.
          if (!sel_valid && !(coin_valid && coin_fits) && tmo_q == TMO_LAST)
            state_d = CHANGE;
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        coin_reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (!gap_q) begin
          // Pulse and decrement share an edge; leave as the last unit goes out.
          chg_pulse_d = 1'b1;
          credit_d    = credit_q - CREDIT_W'(1);
          gap_d       = 1'b1;
          if (credit_q == CREDIT_W'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != CREDIT) tmo_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      tmo_q         <= '0;
      disp_idx_q    <= '0;
      coin_reject_q <= 1'b0;
      sel_nak_q     <= 1'b0;
      chg_pulse_q   <= 1'b0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmo_q         <= tmo_d;
      disp_idx_q    <= disp_idx_d;
      coin_reject_q <= coin_reject_d;
      sel_nak_q     <= sel_nak_d;
      chg_pulse_q   <= chg_pulse_d;
      gap_q         <= gap_d;
    end
  end

  assign coin_reject = coin_reject_q;
  assign sel_nak     = sel_nak_q;
  assign chg_pulse   = chg_pulse_q;
  assign credit      = credit_q;
  assign disp_idx    = disp_idx_q;
  assign disp_req    = (state_q == DISPENSE);
  assign busy        = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule
